// File: rtl/ram4k_arbiter_pkg.sv
// Shared types, sizes and the round-robin pick function for the ram4k arbiter slice.
package ram4k_arbiter_pkg;

    localparam int RAM4K_WORDS = 4096;
    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 16;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM4K_WORDS - 1);

    // Requester slots inside the packed request/grant vectors.
    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    // last_b = 1 means B was served most recently, so A wins a tie.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_b);
        logic [1:0] pick;
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_b ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/ram4k_arbiter_if.sv
// Requester, clear-control and RAM-side signals of the ram4k arbiter.
interface ram4k_arbiter_if;
    import ram4k_arbiter_pkg::*;

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              clear_req;
    logic              busy;

    logic [DATA_W-1:0] ram_in;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_load;
    logic [DATA_W-1:0] ram_out;

    // Master: the requesters plus the external ram4k instance.
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        output clear_req,
        input  busy,
        input  ram_in, ram_address, ram_load,
        output ram_out
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        input  clear_req,
        output busy,
        output ram_in, ram_address, ram_load,
        input  ram_out
    );

endinterface

// File: rtl/ram4k_arbiter_rr.sv
// Two-requester round-robin arbiter (arbiter2_rr): one-hot combinational grant, owns the last pointer.
module ram4k_arbiter_rr
    import ram4k_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic r_last_b;

    assign gnt = enable ? rr_pick(req, r_last_b) : 2'b00;

    // Pointer starts at B so A takes the first conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_b <= 1'b1;
        end else if (|gnt) begin
            r_last_b <= gnt[REQ_B];
        end
    end

endmodule

// File: rtl/ram4k_arbiter.sv
// Shares one ram4k between requesters A and B (round robin) and clears all words after reset or on command.
module ram4k_arbiter
    import ram4k_arbiter_pkg::*;
#(
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = 16'h0000,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    ram4k_arbiter_if.slave  bus
);

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_next;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_in_hold;
    logic [ADDR_W-1:0] w_ram_address;
    logic [DATA_W-1:0] w_ram_in;
    logic              w_ram_load;
    logic              w_arb_en;

    logic [1:0]        w_req;
    logic [1:0]        w_we;
    logic [1:0]        w_gnt;
    logic [ADDR_W-1:0] w_addr  [2];
    logic [DATA_W-1:0] w_wdata [2];
    logic [1:0]        w_rvalid;
    logic [DATA_W-1:0] w_rdata [2];

    assign w_req[REQ_A]   = bus.a_req;
    assign w_req[REQ_B]   = bus.b_req;
    assign w_we[REQ_A]    = bus.a_we;
    assign w_we[REQ_B]    = bus.b_we;
    assign w_addr[REQ_A]  = bus.a_addr;
    assign w_addr[REQ_B]  = bus.b_addr;
    assign w_wdata[REQ_A] = bus.a_wdata;
    assign w_wdata[REQ_B] = bus.b_wdata;

    // A pending clear request blocks grants in the same cycle it is seen.
    assign w_arb_en = !reset && (r_state == ST_SERVE) && !bus.clear_req;

    ram4k_arbiter_rr u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (w_req),
        .enable (w_arb_en),
        .gnt    (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RESET_STATE;
            r_clr_cnt   <= '0;
            r_addr_hold <= '0;
            r_in_hold   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_clr_cnt   <= w_clr_cnt_next;
            r_addr_hold <= w_ram_address;
            r_in_hold   <= w_ram_in;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_ram_address  = r_addr_hold;
        w_ram_in       = r_in_hold;
        w_ram_load     = 1'b0;
        if (reset) begin
            w_ram_address = '0;
            w_ram_in      = '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    w_ram_address  = r_clr_cnt;
                    w_ram_in       = CLEAR_VALUE;
                    w_ram_load     = 1'b1;
                    w_clr_cnt_next = r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST_ADDR) begin
                        w_state_next = ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (bus.clear_req) begin
                        w_state_next = ST_CLEAR;
                    end else begin
                        for (int i = 0; i < 2; i++) begin
                            if (w_gnt[i]) begin
                                w_ram_address = w_addr[i];
                                w_ram_in      = w_wdata[i];
                                w_ram_load    = w_we[i];
                            end
                        end
                    end
                end
                default: w_state_next = RESET_STATE;
            endcase
        end
    end

    // Read return per requester: capture ram_out at the end of a read grant.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic              r_rvalid;
            logic [DATA_W-1:0] r_rdata;
            logic              w_rd_hit;

            assign w_rd_hit = w_gnt[gi] && !w_we[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rvalid <= 1'b0;
                    r_rdata  <= '0;
                end else begin
                    r_rvalid <= w_rd_hit;
                    if (w_rd_hit) begin
                        r_rdata <= bus.ram_out;
                    end
                end
            end

            assign w_rvalid[gi] = !reset && r_rvalid;
            assign w_rdata[gi]  = reset ? '0 : r_rdata;
        end
    endgenerate

    assign bus.a_gnt    = w_gnt[REQ_A];
    assign bus.b_gnt    = w_gnt[REQ_B];
    assign bus.a_rvalid = w_rvalid[REQ_A];
    assign bus.b_rvalid = w_rvalid[REQ_B];
    assign bus.a_rdata  = w_rdata[REQ_A];
    assign bus.b_rdata  = w_rdata[REQ_B];

    assign bus.busy        = reset ? CLEAR_ON_RESET : (r_state == ST_CLEAR);
    assign bus.ram_address = w_ram_address;
    assign bus.ram_in      = w_ram_in;
    assign bus.ram_load    = w_ram_load;

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Directed bench for ram4k_arbiter: a clear-on-reset instance with a ram4k model, and a no-clear instance.
module tb_ram4k_arbiter;
    import ram4k_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;
    logic mem_init;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [15:0] mem [4096];

    ram4k_arbiter_if bus0 ();
    ram4k_arbiter_if bus1 ();

    ram4k_arbiter #(.CLEAR_VALUE(16'h0000), .CLEAR_ON_RESET(1'b1)) dut0 (
        .clk(clk), .reset(rst0), .bus(bus0.slave)
    );
    ram4k_arbiter #(.CLEAR_VALUE(16'h0000), .CLEAR_ON_RESET(1'b0)) dut1 (
        .clk(clk), .reset(rst1), .bus(bus1.slave)
    );

    // ram4k model: combinational read, write on the clock edge; starts full of FFFF.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'hFFFF;
        end else if (bus0.ram_load) begin
            mem[bus0.ram_address] <= bus0.ram_in;
        end
    end
    assign bus0.ram_out = mem[bus0.ram_address];
    assign bus1.ram_out = 16'h5A5A;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [11:0] addr, input logic [15:0] wd);
        bus0.a_req = req; bus0.a_we = we; bus0.a_addr = addr; bus0.a_wdata = wd;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [11:0] addr, input logic [15:0] wd);
        bus0.b_req = req; bus0.b_we = we; bus0.b_addr = addr; bus0.b_wdata = wd;
    endtask

    task automatic test_reset();
        drive_a(1'b1, 1'b0, 12'h001, 16'h0);
        drive_b(1'b1, 1'b0, 12'h002, 16'h0);
        bus1.a_req = 1'b1;
        step();
        $display("[TB] reset: gnt=%b%b load=%b addr=%h busy0=%b busy1=%b",
                 bus0.a_gnt, bus0.b_gnt, bus0.ram_load, bus0.ram_address, bus0.busy, bus1.busy);
        n_tests++; if ({bus0.a_gnt, bus0.b_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b want 00", {bus0.a_gnt, bus0.b_gnt}); end
        n_tests++; if (bus0.ram_load !== 1'b0) begin n_fail++; $display("FAIL rst_load: got %b want 0", bus0.ram_load); end
        n_tests++; if ({bus0.a_rvalid, bus0.b_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", {bus0.a_rvalid, bus0.b_rvalid}); end
        n_tests++; if ({bus0.a_rdata, bus0.b_rdata} !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", {bus0.a_rdata, bus0.b_rdata}); end
        n_tests++; if ({bus0.ram_address, bus0.ram_in} !== 28'h0) begin n_fail++; $display("FAIL rst_ram_bus: got %h want 0", {bus0.ram_address, bus0.ram_in}); end
        n_tests++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy0: got %b want 1", bus0.busy); end
        n_tests++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy1: got %b want 0", bus1.busy); end
        n_tests++; if (bus1.a_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt1: got %b want 0", bus1.a_gnt); end
        drive_a(1'b0, 1'b0, 12'h0, 16'h0);
        drive_b(1'b0, 1'b0, 12'h0, 16'h0);
        bus1.a_req = 1'b0;
    endtask

    task automatic test_clear_sequence();
        int errs;
        errs = 0;
        rst0 = 1'b0;
        #1;
        for (int i = 0; i < 4096; i++) begin
            if (bus0.busy !== 1'b1 || bus0.ram_load !== 1'b1 || bus0.ram_address !== 12'(i) || bus0.ram_in !== 16'h0) begin
                errs++;
                if (errs == 1) $display("FAIL clr_seq: cycle %0d got busy=%b load=%b addr=%h in=%h want 1 1 %h 0000",
                                        i, bus0.busy, bus0.ram_load, bus0.ram_address, bus0.ram_in, 12'(i));
            end
            step();
        end
        $display("[TB] clear sequence: 4096 cycles, %0d bad", errs);
        n_tests++; if (errs != 0) n_fail++;
        n_tests++; if (bus0.busy !== 1'b0 || bus0.ram_load !== 1'b0) begin n_fail++; $display("FAIL clr_end: got busy=%b load=%b want 0 0", bus0.busy, bus0.ram_load); end
    endtask

    task automatic test_clear_readback();
        logic [11:0] addrs [3];
        addrs[0] = 12'h000; addrs[1] = 12'h7FF; addrs[2] = 12'hFFF;
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b1, 1'b0, addrs[k], 16'h0);
            #1;
            n_tests++; if (bus0.a_gnt !== 1'b1) begin n_fail++; $display("FAIL rb_gnt: addr %h got %b want 1", addrs[k], bus0.a_gnt); end
            step();
            drive_a(1'b0, 1'b0, 12'h0, 16'h0);
            #1;
            $display("[TB] A read %h -> rvalid=%b data=%h", addrs[k], bus0.a_rvalid, bus0.a_rdata);
            n_tests++; if (bus0.a_rvalid !== 1'b1 || bus0.a_rdata !== 16'h0000) begin n_fail++; $display("FAIL rb_data: addr %h got %b/%h want 1/0000", addrs[k], bus0.a_rvalid, bus0.a_rdata); end
            step();
        end
    endtask

    task automatic test_write_read();
        drive_a(1'b1, 1'b1, 12'h123, 16'hBEEF);
        #1;
        $display("[TB] A write 123=BEEF gnt=%b load=%b addr=%h in=%h", bus0.a_gnt, bus0.ram_load, bus0.ram_address, bus0.ram_in);
        n_tests++; if ({bus0.a_gnt, bus0.ram_load} !== 2'b11) begin n_fail++; $display("FAIL wr_gnt_load: got %b want 11", {bus0.a_gnt, bus0.ram_load}); end
        n_tests++; if (bus0.ram_address !== 12'h123 || bus0.ram_in !== 16'hBEEF) begin n_fail++; $display("FAIL wr_bus: got %h/%h want 123/beef", bus0.ram_address, bus0.ram_in); end
        step();
        drive_a(1'b1, 1'b0, 12'h123, 16'h0);
        #1;
        n_tests++; if ({bus0.a_gnt, bus0.ram_load, bus0.a_rvalid} !== 3'b100) begin n_fail++; $display("FAIL rd_gnt: got gnt/load/rvalid %b want 100", {bus0.a_gnt, bus0.ram_load, bus0.a_rvalid}); end
        step();
        drive_a(1'b0, 1'b0, 12'h0, 16'h0);
        #1;
        $display("[TB] A read 123 -> rvalid=%b data=%h", bus0.a_rvalid, bus0.a_rdata);
        n_tests++; if (bus0.a_rvalid !== 1'b1 || bus0.a_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %b/%h want 1/beef", bus0.a_rvalid, bus0.a_rdata); end
        n_tests++; if (bus0.ram_load !== 1'b0 || bus0.ram_address !== 12'h123) begin n_fail++; $display("FAIL idle_hold: got load=%b addr=%h want 0 123", bus0.ram_load, bus0.ram_address); end
        step();
        n_tests++; if (bus0.a_rvalid !== 1'b0 || bus0.a_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_pulse: got %b/%h want 0/beef", bus0.a_rvalid, bus0.a_rdata); end
    endtask

    task automatic test_alternate();
        logic exp_a;
        drive_a(1'b1, 1'b1, 12'h010, 16'h1111);
        #1;
        n_tests++; if (bus0.a_gnt !== 1'b1) begin n_fail++; $display("FAIL alt_wa: got %b want 1", bus0.a_gnt); end
        step();
        drive_a(1'b0, 1'b0, 12'h0, 16'h0);
        drive_b(1'b1, 1'b1, 12'h020, 16'h2222);
        #1;
        n_tests++; if (bus0.b_gnt !== 1'b1) begin n_fail++; $display("FAIL alt_wb: got %b want 1", bus0.b_gnt); end
        step();
        drive_a(1'b1, 1'b0, 12'h010, 16'h0);
        drive_b(1'b1, 1'b0, 12'h020, 16'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            exp_a = (c % 2 == 0);
            $display("[TB] conflict cycle %0d: gnt a=%b b=%b rvalid a=%b b=%b", c, bus0.a_gnt, bus0.b_gnt, bus0.a_rvalid, bus0.b_rvalid);
            n_tests++; if ({bus0.a_gnt, bus0.b_gnt} !== {exp_a, !exp_a}) begin n_fail++; $display("FAIL alt_gnt: cycle %0d got %b want %b", c, {bus0.a_gnt, bus0.b_gnt}, {exp_a, !exp_a}); end
            if (c > 0) begin
                n_tests++; if ({bus0.a_rvalid, bus0.b_rvalid} !== {!exp_a, exp_a}) begin n_fail++; $display("FAIL alt_rvalid: cycle %0d got %b want %b", c, {bus0.a_rvalid, bus0.b_rvalid}, {!exp_a, exp_a}); end
                n_tests++; if ((exp_a ? bus0.b_rdata : bus0.a_rdata) !== (exp_a ? 16'h2222 : 16'h1111)) begin n_fail++; $display("FAIL alt_rdata: cycle %0d got a=%h b=%h", c, bus0.a_rdata, bus0.b_rdata); end
            end
            step();
        end
        drive_a(1'b0, 1'b0, 12'h0, 16'h0);
        drive_b(1'b0, 1'b0, 12'h0, 16'h0);
        #1;
        n_tests++; if ({bus0.a_rvalid, bus0.b_rvalid} !== 2'b01 || bus0.b_rdata !== 16'h2222 || bus0.a_rdata !== 16'h1111) begin
            n_fail++; $display("FAIL alt_last: got rvalid=%b a=%h b=%h want 01 1111 2222", {bus0.a_rvalid, bus0.b_rvalid}, bus0.a_rdata, bus0.b_rdata); end
        step();
    endtask

    task automatic test_b_then_conflict();
        drive_b(1'b1, 1'b0, 12'h020, 16'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if ({bus0.a_gnt, bus0.b_gnt} !== 2'b01) begin n_fail++; $display("FAIL bonly_gnt: read %0d got %b want 01", k, {bus0.a_gnt, bus0.b_gnt}); end
            step();
        end
        drive_a(1'b1, 1'b0, 12'h010, 16'h0);
        #1;
        $display("[TB] B x3 then conflict: gnt a=%b b=%b", bus0.a_gnt, bus0.b_gnt);
        n_tests++; if ({bus0.a_gnt, bus0.b_gnt} !== 2'b10) begin n_fail++; $display("FAIL conf_win: got %b want 10", {bus0.a_gnt, bus0.b_gnt}); end
        step();
        drive_a(1'b0, 1'b0, 12'h0, 16'h0);
        #1;
        n_tests++; if ({bus0.a_gnt, bus0.b_gnt} !== 2'b01) begin n_fail++; $display("FAIL conf_next: got %b want 01", {bus0.a_gnt, bus0.b_gnt}); end
        n_tests++; if (bus0.a_rvalid !== 1'b1 || bus0.a_rdata !== 16'h1111) begin n_fail++; $display("FAIL conf_ardata: got %b/%h want 1/1111", bus0.a_rvalid, bus0.a_rdata); end
        step();
        drive_b(1'b0, 1'b0, 12'h0, 16'h0);
        #1;
        n_tests++; if (bus0.b_rvalid !== 1'b1 || bus0.b_rdata !== 16'h2222 || bus0.a_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL conf_brdata: got b=%b/%h a_rvalid=%b want 1/2222 0", bus0.b_rvalid, bus0.b_rdata, bus0.a_rvalid); end
        step();
    endtask

    task automatic test_clear_cmd();
        int cnt;
        drive_a(1'b1, 1'b0, 12'h010, 16'h0);
        bus0.clear_req = 1'b1;
        #1;
        $display("[TB] clear_req with A pending: gnt=%b load=%b busy=%b", bus0.a_gnt, bus0.ram_load, bus0.busy);
        n_tests++; if ({bus0.a_gnt, bus0.ram_load, bus0.busy} !== 3'b000) begin n_fail++; $display("FAIL clrcmd_block: got gnt/load/busy %b want 000", {bus0.a_gnt, bus0.ram_load, bus0.busy}); end
        step();
        bus0.clear_req = 1'b0;
        #1;
        n_tests++; if ({bus0.busy, bus0.a_gnt, bus0.ram_load} !== 3'b101 || bus0.ram_address !== 12'h000) begin
            n_fail++; $display("FAIL clrcmd_start: got busy/gnt/load %b addr %h want 101 000", {bus0.busy, bus0.a_gnt, bus0.ram_load}, bus0.ram_address); end
        cnt = 0;
        while (bus0.a_gnt !== 1'b1 && cnt < 5000) begin
            step();
            cnt++;
        end
        $display("[TB] A granted %0d cycles after clear start", cnt);
        n_tests++; if (cnt != 4096) begin n_fail++; $display("FAIL clrcmd_len: got %0d want 4096", cnt); end
        step();
        drive_a(1'b0, 1'b0, 12'h0, 16'h0);
        #1;
        n_tests++; if (bus0.a_rvalid !== 1'b1 || bus0.a_rdata !== 16'h0000) begin n_fail++; $display("FAIL clrcmd_data: got %b/%h want 1/0000", bus0.a_rvalid, bus0.a_rdata); end
        step();
    endtask

    task automatic test_reset_midclear();
        int cnt;
        drive_a(1'b1, 1'b1, 12'h123, 16'hBEEF);
        step();
        drive_a(1'b1, 1'b0, 12'h123, 16'h0);
        #1;
        n_tests++; if (bus0.a_gnt !== 1'b1) begin n_fail++; $display("FAIL drop_gnt: got %b want 1", bus0.a_gnt); end
        step();
        drive_a(1'b0, 1'b0, 12'h0, 16'h0);
        rst0 = 1'b1;
        #1;
        $display("[TB] reset after read grant: rvalid=%b rdata=%h", bus0.a_rvalid, bus0.a_rdata);
        n_tests++; if (bus0.a_rvalid !== 1'b0 || bus0.a_rdata !== 16'h0000) begin n_fail++; $display("FAIL drop_rvalid: got %b/%h want 0/0000", bus0.a_rvalid, bus0.a_rdata); end
        step();
        rst0 = 1'b0;
        #1;
        repeat (1000) step();
        n_tests++; if (bus0.ram_address !== 12'd1000 || bus0.busy !== 1'b1) begin n_fail++; $display("FAIL mid_count: got addr %0d busy %b want 1000 1", bus0.ram_address, bus0.busy); end
        rst0 = 1'b1;
        #1;
        n_tests++; if ({bus0.busy, bus0.ram_load} !== 2'b10 || bus0.ram_address !== 12'h000) begin
            n_fail++; $display("FAIL mid_rst: got busy/load %b addr %h want 10 000", {bus0.busy, bus0.ram_load}, bus0.ram_address); end
        step();
        rst0 = 1'b0;
        #1;
        n_tests++; if (bus0.ram_load !== 1'b1 || bus0.ram_address !== 12'h000) begin n_fail++; $display("FAIL mid_restart: got load %b addr %h want 1 000", bus0.ram_load, bus0.ram_address); end
        cnt = 0;
        while (bus0.busy === 1'b1 && cnt < 5000) begin
            step();
            cnt++;
        end
        $display("[TB] busy after mid-clear reset lasted %0d cycles", cnt);
        n_tests++; if (cnt != 4096) begin n_fail++; $display("FAIL mid_len: got %0d want 4096", cnt); end
    endtask

    task automatic test_no_clear_on_reset();
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 12'h005;
        rst1 = 1'b0;
        #1;
        $display("[TB] no-clear instance: gnt=%b busy=%b addr=%h", bus1.a_gnt, bus1.busy, bus1.ram_address);
        n_tests++; if ({bus1.a_gnt, bus1.busy, bus1.ram_load} !== 3'b100) begin n_fail++; $display("FAIL nc_gnt: got gnt/busy/load %b want 100", {bus1.a_gnt, bus1.busy, bus1.ram_load}); end
        n_tests++; if (bus1.ram_address !== 12'h005) begin n_fail++; $display("FAIL nc_addr: got %h want 005", bus1.ram_address); end
        step();
        bus1.a_req = 1'b0;
        #1;
        n_tests++; if (bus1.a_rvalid !== 1'b1 || bus1.a_rdata !== 16'h5A5A) begin n_fail++; $display("FAIL nc_rdata: got %b/%h want 1/5a5a", bus1.a_rvalid, bus1.a_rdata); end
        step();
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; mem_init = 1'b1;
        drive_a(1'b0, 1'b0, 12'h0, 16'h0);
        drive_b(1'b0, 1'b0, 12'h0, 16'h0);
        bus0.clear_req = 1'b0;
        bus1.a_req = 1'b0; bus1.a_we = 1'b0; bus1.a_addr = 12'h0; bus1.a_wdata = 16'h0;
        bus1.b_req = 1'b0; bus1.b_we = 1'b0; bus1.b_addr = 12'h0; bus1.b_wdata = 16'h0;
        bus1.clear_req = 1'b0;
        step();
        mem_init = 1'b0;
        test_reset();
        test_clear_sequence();
        test_clear_readback();
        test_write_read();
        test_alternate();
        test_b_then_conflict();
        test_clear_cmd();
        test_reset_midclear();
        test_no_clear_on_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram4k_arbiter.md
# ram4k_arbiter

Shares one `ram4k` (4096 x 16, combinational read, write on clock edge) between two requesters, A and B, using round-robin arbitration. It also contains a clear sequencer that writes a fixed value to all 4096 words after reset or on command. It sits between the CPU-side and peripheral-side (e.g. screen/DMA) masters and the `ram4k` instance, and drives that instance's `in`/`address`/`load` directly.

## Interface
Parameters:
- `CLEAR_VALUE`, 16'h0000, word written by the clear sequencer
- `CLEAR_ON_RESET`, 1, 1 = run a full clear after reset; 0 = go straight to serving

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `a_req`  in  1  requester A access request; held with fields until `a_gnt`
- `a_we`  in  1  1 = write, 0 = read
- `a_addr`  in  12  word address
- `a_wdata`  in  16  write data
- `a_gnt`  out  1  access accepted this cycle (combinational)
- `a_rvalid`  out  1  one-cycle pulse, `a_rdata` valid
- `a_rdata`  out  16  registered read data
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as A
- `clear_req`  in  1  start a full-memory clear (sampled each edge)
- `busy`  out  1  clear in progress; no grants
- `ram_in`  out  16  to `ram4k.in`
- `ram_address`  out  12  to `ram4k.address`
- `ram_load`  out  1  to `ram4k.load`
- `ram_out`  in  16  from `ram4k.out`

## Operation
- States: CLEAR, SERVE. Reset state is CLEAR if `CLEAR_ON_RESET`, else SERVE. Clear counter resets to 0.
- CLEAR: `ram_address` = counter, `ram_in` = `CLEAR_VALUE`, `ram_load` = 1, and the counter increments every cycle. After the write at address 4095, the counter wraps to 0 and the state goes to SERVE. Both gnts are 0. `clear_req` is ignored; a clear in progress never restarts.
- SERVE, `clear_req`=1: no grant and no RAM access this cycle; the next state is CLEAR. `clear_req` takes precedence over pending requests.
- SERVE, one request: it is granted in the same cycle. Its address drives `ram_address`, `ram_load` = `x_we`, and `ram_in` = `x_wdata`.
- SERVE, both requesting: the requester not served most recently wins. The loser keeps its request asserted and wins the next cycle.
- `last` pointer: updates only on a grant, to the winner. Its reset value is B, so A wins the first conflict.
- A granted write commits at the clock edge ending the grant cycle.
- A granted read registers `ram_out` into `x_rdata` at that edge. `x_rvalid` = 1 for exactly the next cycle. `x_rdata` holds its value until the next read by the same requester.
- With no grant, `ram_load` = 0, and `ram_address`/`ram_in` hold the values from the last grant or clear (registered mux select).
- `busy` = (state == CLEAR).

## Timing
- Grant latency is 0 cycles when the requester is uncontended and not blocked by a clear. Worst-case wait under contention is 1 cycle.
- Read data latency is 1 cycle after `gnt`. Throughput is one access per cycle in total across A and B.
- A clear takes 4096 cycles. The first write occurs in the first cycle with `reset`=0, or in the cycle after `clear_req` is sampled. `busy` falls in cycle 4097.
- Outputs while `reset`=1:
  - `a_gnt`/`b_gnt` = 0
  - `ram_load` = 0
  - `a_rvalid`/`b_rvalid` = 0
  - `a_rdata`/`b_rdata` = 0
  - `ram_address` = 0
  - `ram_in` = 0
  - `busy` = `CLEAR_ON_RESET`
- Reset mid-clear: the clear aborts, the counter returns to 0, and the sequence restarts from address 0 if `CLEAR_ON_RESET`.
- Reset on the cycle after a read grant: the pending `rvalid` is dropped.
- Read and write to the same address in consecutive grants: the read after the write returns the new data. A read and write in the same cycle are impossible, since only one grant is issued per cycle.

## Structure
- `src/ram4k_arbiter_defs.vh` (include-guarded) holds the state encodings (`ST_CLEAR`, `ST_SERVE`) and `RAM4K_WORDS` = 4096.
- Sub-module `arbiter2_rr`: inputs `clk`, `reset`, `req[1:0]`, `enable`; outputs `gnt[1:0]` one-hot. It owns the `last` pointer.
- The top level owns the FSM, clear counter, RAM mux and read-return registers. `ram4k` is instantiated outside the block; an integration bench wires the two together.

## Test plan
- Reset with `CLEAR_ON_RESET`=1, release, count cycles -> `busy`=1 for exactly 4096 cycles. `ram_load`=1 with addresses 0..4095 in order. Reads afterwards return 16'h0000 at addresses 0, 2047 and 4095.
- A writes 16'hBEEF to 12'h123, then A reads 12'h123 -> `a_gnt` in the same cycle each time. `a_rvalid` pulses once, 1 cycle after the read grant, with `a_rdata`=16'hBEEF.
- A and B both hold read requests for 4 cycles after reset -> grant order A, B, A, B. Each `rvalid` goes to the correct side with that side's data.
- B alone requests three reads, then A and B conflict -> A wins the conflict (last=B). B is granted the following cycle.
- `clear_req` and `a_req` both asserted in SERVE -> `a_gnt`=0 that cycle. `busy`=1 the next cycle. `a_gnt` occurs only after 4096 clear cycles.
- `reset` at clear count 1000, `CLEAR_ON_RESET`=1 -> the clear restarts at address 0 and `busy` lasts a full 4096 cycles after release. With `CLEAR_ON_RESET`=0, `busy`=0 and the first request is granted immediately.
